// File: rtl/nibbler_sequencer.sv
//------------------------------------------------------------------------------
// Module      : nibbler_sequencer
// Description : Run/step/halt sequencer for a 4-bit two-phase CPU. Holds the
//               program counter, instruction register and ALU flags, builds
//               the microcode decoder address and gates the decoder's control
//               word onto the datapath only while execution is active.
//
// Ports
//   clk, reset         : single clock; synchronous active-high reset
//   run, step          : free-run level / single-instruction request
//   bp_en, bp_addr     : breakpoint enable and address (NIBBLER_BKPT_EN only)
//   prog_data [7:0]    : program-memory byte at pc (combinational read)
//   alu_c, alu_z       : ALU carry / zero results
//   cw_in  [12:0]      : control word from the microcode decoder
//   dec_addr [6:0]     : {opcode, C, Z, phase} to the microcode decoder
//   pc [11:0]          : program counter
//   operand [3:0]      : low nibble of the instruction
//   mem_addr [11:0]    : {operand, prog_data}, jump / memory address
//   cw_out [12:0]      : control word to datapath, zero when not active
//   halted, retire     : HALTED status / last cycle of an instruction
//
// Build option : define NIBBLER_BKPT_EN to add the breakpoint ports and logic.
//
// Revision     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module nibbler_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
`ifdef NIBBLER_BKPT_EN
  input  logic        bp_en,
  input  logic [11:0] bp_addr,
`endif
  input  logic [7:0]  prog_data,
  input  logic        alu_c,
  input  logic        alu_z,
  input  logic [12:0] cw_in,
  output logic [6:0]  dec_addr,
  output logic [11:0] pc,
  output logic [3:0]  operand,
  output logic [11:0] mem_addr,
  output logic [12:0] cw_out,
  output logic        halted,
  output logic        retire
);

  // Control word bit positions used by the sequencer itself
  localparam int c_CW_INC_PC    = 12;
  localparam int c_CW_LOAD_PC   = 11;
  localparam int c_CW_LOAD_FLAG = 9;

  typedef enum logic [1:0] {
    S_HALTED   = 2'd0,
    S_RUNNING  = 2'd1,
    S_STEPPING = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_phase;
  logic [11:0] r_pc;
  logic [7:0]  r_instr;
  logic        r_c;
  logic        r_z;

  logic        w_bp_hit;
  logic        w_active;

`ifdef NIBBLER_BKPT_EN
  // A breakpoint only stops free-running execution at an instruction
  // boundary; stepping deliberately ignores it so the halted instruction
  // can be executed.
  assign w_bp_hit = (r_state == S_RUNNING) && !r_phase && bp_en && (r_pc == bp_addr);
`else
  assign w_bp_hit = 1'b0;
`endif

  assign w_active = ((r_state == S_RUNNING) || (r_state == S_STEPPING)) && !w_bp_hit;

  assign pc       = r_pc;
  assign operand  = r_instr[3:0];
  assign mem_addr = {r_instr[3:0], prog_data};
  assign dec_addr = {r_instr[7:4], r_c, r_z, r_phase};
  assign cw_out   = w_active ? cw_in : 13'd0;
  assign halted   = (r_state == S_HALTED);
  assign retire   = w_active && r_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_HALTED;
      r_phase <= 1'b0;
      r_pc    <= 12'h000;
      r_instr <= 8'h00;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        S_HALTED: begin
          if (!r_phase) begin
            if (run) begin
              r_state <= S_RUNNING;
            end else if (step) begin
              r_state <= S_STEPPING;
            end
          end
        end
        S_RUNNING: begin
          // run is only looked at once the instruction has finished
          if (w_bp_hit) begin
            r_state <= S_HALTED;
          end else if (r_phase && !run) begin
            r_state <= S_HALTED;
          end
        end
        S_STEPPING: begin
          if (r_phase) begin
            r_state <= S_HALTED;
          end
        end
        default: begin
          r_state <= S_HALTED;
        end
      endcase

      if (w_active) begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_instr <= prog_data;
        end
        if (cw_in[c_CW_LOAD_PC]) begin
          r_pc <= mem_addr;
        end else if (cw_in[c_CW_INC_PC]) begin
          r_pc <= r_pc + 12'd1;
        end
        if (cw_in[c_CW_LOAD_FLAG]) begin
          r_c <= alu_c;
          r_z <= alu_z;
        end
      end
    end
  end

endmodule

`default_nettype wire
